ipf_lcu_feeder: RTL
===================

IPF_LCU_FEEDER -- requirements
Module: ipf_lcu_feeder

Interface
REQ-001 SHALL have parameters: IMG_W, default 128, image width/height in pixels; LCU_W, default 16, LCU edge in pixels; N_LCU, default 8, LCUs per image row/column.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins one image.
- img_rd_addr  out  14  image memory address = lcu_y*2048 + row*128 + lcu_x*16 + col.
- img_rd_data  in  8  image pixel; valid one cycle after img_rd_addr (synchronous read).
- prm_rd_addr  out  6  LCU parameter table address = lcu_y*8 + lcu_x.
- prm_rd_data  in  24  {type[23:22], band_pos[21:17], wo_class[16], offset[15:0]}; one-cycle latency.
- busy  in  1  filter cannot accept pixels.
- in_en  out  1  din valid this cycle.
- din  out  8  pixel to filter.
- ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset  out  2/5/1/16  current LCU parameters.
- lcu_x, lcu_y  out  3/3  current LCU coordinates.
- lcu_size  out  2  constant 2'd0 (16x16).
- done  out  1  one-cycle pulse after last pixel of LCU (7,7).

Function
REQ-003 SHALL implement FSM states IDLE, PFETCH, PLOAD, WAITB, STREAM, DONE.
REQ-004 IDLE -> PFETCH on start; start ignored outside IDLE.
REQ-005 PFETCH: drive prm_rd_addr; next PLOAD; PLOAD registers prm_rd_data into the ipf_* outputs; next WAITB.
REQ-006 ipf_*, lcu_x, lcu_y SHALL be stable from PLOAD+1 until the 256th pixel of that LCU is sent.
REQ-007 WAITB: issue first image read (row 0, col 0); -> STREAM when busy==0.
REQ-008 STREAM: in_en = (busy==0) & (prefetch buffer non-empty); each in_en cycle transfers exactly one pixel in raster order (col fastest, then row).
REQ-009 Prefetch buffer SHALL be 2 entries deep; a read SHALL be issued only when occupancy plus in-flight reads < 2; no pixel is lost or duplicated when busy toggles at any cycle.
REQ-010 With busy held 0, sustained throughput SHALL be one pixel per cycle after the first pixel.
REQ-011 busy rising mid-LCU: in_en SHALL drop in the same cycle (combinational on busy); streaming resumes with the next unsent pixel.
REQ-012 After pixel (15,15): lcu_x increments; at wrap 7 -> 0, lcu_y increments; -> PFETCH; after LCU (7,7) -> DONE.
REQ-013 DONE: pulse done for one cycle, -> IDLE; lcu_x, lcu_y reset to 0.
REQ-014 din SHALL come from the buffer head register (registered output path, no combinational path from img_rd_data).
REQ-015 Address arithmetic SHALL be 14-bit unsigned with no overflow for the default parameters.

Reset
REQ-016 reset SHALL asynchronously force state IDLE, buffer empty, in_en 0, din 0, done 0, img_rd_addr 0, prm_rd_addr 0, ipf_* 0, lcu_x 0, lcu_y 0.
REQ-017 reset asserted mid-STREAM SHALL abort the image; no in_en until the next start.

Structure
REQ-018 IMG_W, LCU_W, N_LCU, state encoding and the prm_rd_data field offsets SHALL be placed in a shared package ipf_pkg, also used by the filter.
REQ-019 The 2-entry prefetch buffer SHALL be a sub-module ipf_pix_fifo (push, pop, full, empty, data).

Verification
REQ-020 start, busy=0 after PLOAD, memory holds mem[a]=a[7:0] -> 256 in_en pulses for LCU(0,0); din sequence 0x00..0x0F, then 0x80..0x8F (row 1), ..., no gaps after the first pixel.
REQ-021 busy toggles 1/0 every cycle during LCU(2,3) -> din stream identical to the busy=0 run; exactly 256 in_en; no in_en while busy=1.
REQ-022 prm_rd_data=0x9A_5A5A at address 9 -> during LCU(1,1): ipf_type=2, ipf_band_pos=13, ipf_wo_class=0, ipf_offset=0x5A5A, stable across all 256 pixels.
REQ-023 Full image -> 16384 in_en total, lcu_x/lcu_y step (0,0)..(7,0),(0,1)..(7,7), one done pulse after the last pixel.
REQ-024 reset at pixel 100 of LCU(0,0) -> in_en 0 immediately; outputs at reset values; new start restarts at address 0.
REQ-025 start pulsed during STREAM -> ignored; pixel sequence and done timing unchanged.

Source files
------------

// File: rtl/ipf_pkg.sv
// Shared definitions for the in-loop post filter (IPF) block: image and LCU
// geometry, bus widths, feeder FSM state encoding and the bit layout of the
// 24-bit LCU parameter word. Used by the LCU feeder and by the filter.
package ipf_pkg;

  localparam int IPF_IMG_W = 128;  // image width/height in pixels
  localparam int IPF_LCU_W = 16;   // LCU edge in pixels
  localparam int IPF_N_LCU = 8;    // LCUs per image row/column

  localparam int IMG_AW = 14;      // image memory address width
  localparam int PRM_AW = 6;       // parameter table address width
  localparam int PRM_W  = 24;      // parameter word width
  localparam int PIX_W  = 8;       // pixel width
  localparam int LCU_CW = 3;       // LCU coordinate width

  // Parameter word layout: {type, band_pos, wo_class, offset}
  localparam int PRM_TYPE_LSB = 22;
  localparam int PRM_BAND_LSB = 17;
  localparam int PRM_WO_LSB   = 16;
  localparam int PRM_OFF_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PFETCH, ST_PLOAD, ST_WAITB, ST_STREAM, ST_DONE
  } ipf_state_e;

  typedef struct packed {
    logic [1:0]  typ;
    logic [4:0]  band_pos;
    logic        wo_class;
    logic [15:0] offset;
  } ipf_prm_t;

  function automatic ipf_prm_t prm_unpack(input logic [PRM_W-1:0] w);
    ipf_prm_t p;
    p.typ      = w[PRM_TYPE_LSB +: 2];
    p.band_pos = w[PRM_BAND_LSB +: 5];
    p.wo_class = w[PRM_WO_LSB];
    p.offset   = w[PRM_OFF_LSB +: 16];
    return p;
  endfunction

endpackage

// File: rtl/ipf_lcu_feeder_if.sv
// Feeder -> filter link: pixel stream with busy back-pressure, the current
// LCU's filter parameters and coordinates, and the end-of-image pulse.
//   master (feeder): drives in_en, din, ipf_*, lcu_*, done; samples busy.
//   slave  (filter): drives busy; samples the rest.
interface ipf_lcu_feeder_if;
  import ipf_pkg::*;

  logic              busy;
  logic              in_en;
  logic [PIX_W-1:0]  din;
  logic [1:0]        ipf_type;
  logic [4:0]        ipf_band_pos;
  logic              ipf_wo_class;
  logic [15:0]       ipf_offset;
  logic [LCU_CW-1:0] lcu_x;
  logic [LCU_CW-1:0] lcu_y;
  logic [1:0]        lcu_size;
  logic              done;

  modport master (
    input  busy,
    output in_en, din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
           lcu_x, lcu_y, lcu_size, done
  );

  modport slave (
    output busy,
    input  in_en, din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
           lcu_x, lcu_y, lcu_size, done
  );
endinterface

// File: rtl/ipf_pix_fifo.sv
// Two-entry pixel prefetch buffer. The head entry is a register driven
// straight onto 'data', so the consumer never sees a combinational path
// from the write side.
//   clk, reset     : clock, async active-high reset (buffer empty, data 0)
//   push, wdata    : write one entry (caller guarantees not full or popping)
//   pop            : drop the head entry (caller guarantees not empty)
//   full, empty    : occupancy flags
//   data           : head entry
module ipf_pix_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] tail_q;
  logic [1:0]        cnt_q;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data   <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (pop && cnt_q == 2'd2) begin
        data <= tail_q;
        if (push) tail_q <= wdata;
      end else if (pop || cnt_q == 2'd0) begin
        // head is free after this cycle: new data goes straight to head
        if (push) data <= wdata;
      end else if (push) begin
        tail_q <= wdata;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/ipf_lcu_feeder.sv
// Walks an image LCU by LCU in raster order (x fastest), loads each LCU's
// filter parameters, then streams its pixels (col fastest, then row) to the
// filter under busy back-pressure. Pixels are prefetched from a synchronous
// one-cycle-latency image memory into a 2-entry buffer.
//   clk, reset   : clock, async active-high reset
//   start        : one-cycle pulse, begins an image (ignored unless idle)
//   img_rd_addr  : image address, lcu_y*2048 + row*128 + lcu_x*16 + col
//   img_rd_data  : pixel returned one cycle after img_rd_addr
//   prm_rd_addr  : parameter table address, lcu_y*8 + lcu_x
//   prm_rd_data  : parameter word returned one cycle after prm_rd_addr
//   flt          : filter link (busy in; pixel stream, params, coords, done out)
module ipf_lcu_feeder
  import ipf_pkg::*;
#(
  parameter int IMG_W = IPF_IMG_W,
  parameter int LCU_W = IPF_LCU_W,
  parameter int N_LCU = IPF_N_LCU
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [IMG_AW-1:0] img_rd_addr,
  input  logic [PIX_W-1:0]  img_rd_data,
  output logic [PRM_AW-1:0] prm_rd_addr,
  input  logic [PRM_W-1:0]  prm_rd_data,
  ipf_lcu_feeder_if.master  flt
);
  localparam int PW = $clog2(LCU_W);  // row/col index width

  ipf_state_e        state_q, state_d;
  logic [LCU_CW-1:0] lcu_x_q, lcu_y_q;
  logic [2*PW:0]     rd_cnt_q;   // next pixel to read; MSB set = all read
  logic [2*PW-1:0]   snt_cnt_q;  // pixels sent in this LCU
  logic              inflight_q; // read issued last cycle, data arrives now
  ipf_prm_t          prm_q;

  logic              fifo_full, fifo_empty;
  logic [PIX_W-1:0]  fifo_head;
  logic [1:0]        occ;
  logic              pop, room, issue;
  logic              last_pix, last_lcu;

  assign occ      = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign pop      = (state_q == ST_STREAM) && !flt.busy && !fifo_empty;
  // Occupancy counted after this cycle's pop, so a pop frees a slot for a
  // read in the same cycle and the pipe sustains one pixel per cycle.
  assign room     = !rd_cnt_q[2*PW] &&
                    ((3'(occ) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
  assign last_pix = &snt_cnt_q;
  assign last_lcu = (lcu_x_q == LCU_CW'(N_LCU-1)) &&
                    (lcu_y_q == LCU_CW'(N_LCU-1));

  assign img_rd_addr = IMG_AW'(int'(lcu_y_q) * LCU_W * IMG_W +
                               int'(rd_cnt_q[2*PW-1:PW]) * IMG_W +
                               int'(lcu_x_q) * LCU_W +
                               int'(rd_cnt_q[PW-1:0]));
  assign prm_rd_addr = PRM_AW'(int'(lcu_y_q) * N_LCU + int'(lcu_x_q));

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_PFETCH;
      ST_PFETCH: state_d = ST_PLOAD;
      ST_PLOAD:  state_d = ST_WAITB;
      ST_WAITB: begin
        issue = room;
        if (!flt.busy) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        issue = room;
        if (pop && last_pix) state_d = last_lcu ? ST_DONE : ST_PFETCH;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lcu_x_q    <= '0;
      lcu_y_q    <= '0;
      rd_cnt_q   <= '0;
      snt_cnt_q  <= '0;
      inflight_q <= 1'b0;
      prm_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) rd_cnt_q  <= rd_cnt_q + 1'b1;
      if (pop)   snt_cnt_q <= snt_cnt_q + 1'b1;
      if (state_q == ST_PLOAD) prm_q <= prm_unpack(prm_rd_data);
      // Coordinates move only once the LCU's last pixel has left.
      if (pop && last_pix) begin
        rd_cnt_q <= '0;
        if (lcu_x_q == LCU_CW'(N_LCU-1)) begin
          lcu_x_q <= '0;
          lcu_y_q <= lcu_y_q + 1'b1;
        end else begin
          lcu_x_q <= lcu_x_q + 1'b1;
        end
      end
      if (state_q == ST_DONE) begin
        lcu_x_q <= '0;
        lcu_y_q <= '0;
      end
    end
  end

  ipf_pix_fifo #(.DATA_W(PIX_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .pop   (pop),
    .wdata (img_rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .data  (fifo_head)
  );

  assign flt.in_en        = pop;
  assign flt.din          = fifo_head;
  assign flt.ipf_type     = prm_q.typ;
  assign flt.ipf_band_pos = prm_q.band_pos;
  assign flt.ipf_wo_class = prm_q.wo_class;
  assign flt.ipf_offset   = prm_q.offset;
  assign flt.lcu_x        = lcu_x_q;
  assign flt.lcu_y        = lcu_y_q;
  assign flt.lcu_size     = 2'd0;
  assign flt.done         = (state_q == ST_DONE);
endmodule
